// File: rtl/ffstdp_update_seq_pkg.sv
// Shared types and sizing helpers for the FF-STDP update sequencer and its index counter.
package ffstdp_update_seq_pkg;

  localparam int DEF_N_PRE          = 256;
  localparam int DEF_N_POST         = 256;
  localparam int DEF_PRE_CNT_WIDTH  = 8;
  localparam int DEF_POST_CNT_WIDTH = 7;
  localparam int DEF_WEIGHT_WIDTH   = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_POST_RD  = 3'd1,
    S_POST_LAT = 3'd2,
    S_SYN_RD   = 3'd3,
    S_SYN_UPD  = 3'd4,
    S_SYN_WR   = 3'd5,
    S_FIN      = 3'd6
  } seq_state_e;

  // Index width for a neuron population; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ffstdp_idx_counter.sv
// Nested post-major / pre-minor synapse index counter with last-index flags.
module ffstdp_idx_counter
  import ffstdp_update_seq_pkg::*;
#(
  parameter int N_PRE   = DEF_N_PRE,
  parameter int N_POST  = DEF_N_POST,
  parameter int PRE_AW  = idx_width(N_PRE),
  parameter int POST_AW = idx_width(N_POST)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  output logic [PRE_AW-1:0]  pre_idx,
  output logic [POST_AW-1:0] post_idx,
  output logic               pre_last,
  output logic               post_last
);

  logic [PRE_AW-1:0]  pre_idx_q,  pre_idx_d;
  logic [POST_AW-1:0] post_idx_q, post_idx_d;

  assign pre_last  = (pre_idx_q  == PRE_AW'(N_PRE - 1));
  assign post_last = (post_idx_q == POST_AW'(N_POST - 1));
  assign pre_idx   = pre_idx_q;
  assign post_idx  = post_idx_q;

  // The post index holds at its last value after the final synapse; only clr rewinds it.
  always_comb begin
    pre_idx_d  = pre_idx_q;
    post_idx_d = post_idx_q;
    if (clr) begin
      pre_idx_d  = '0;
      post_idx_d = '0;
    end else if (adv) begin
      if (!pre_last) begin
        pre_idx_d = pre_idx_q + 1'b1;
      end else begin
        pre_idx_d = '0;
        if (!post_last) begin
          post_idx_d = post_idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_idx_q  <= '0;
      post_idx_q <= '0;
    end else begin
      pre_idx_q  <= pre_idx_d;
      post_idx_q <= post_idx_d;
    end
  end

endmodule

// File: rtl/ffstdp_update_seq.sv
// FF-STDP weight-update sequencer: sweeps all synapses after each window and writes back new weights.
// Optional build macro FFSTDP_SKIP_ZERO_PRE_EN skips the write-back of synapses whose pre count is zero.
module ffstdp_update_seq
  import ffstdp_update_seq_pkg::*;
#(
  parameter int N_PRE          = DEF_N_PRE,
  parameter int N_POST         = DEF_N_POST,
  parameter int PRE_CNT_WIDTH  = DEF_PRE_CNT_WIDTH,
  parameter int POST_CNT_WIDTH = DEF_POST_CNT_WIDTH,
  parameter int WEIGHT_WIDTH   = DEF_WEIGHT_WIDTH,
  parameter int PRE_AW         = idx_width(N_PRE),
  parameter int POST_AW        = idx_width(N_POST)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       IS_POS_IN,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [POST_AW-1:0]         POST_CNT_ADDR,
  input  logic [POST_CNT_WIDTH-1:0]  POST_CNT_RDATA,
  output logic [PRE_AW-1:0]          PRE_CNT_ADDR,
  input  logic [PRE_CNT_WIDTH-1:0]   PRE_CNT_RDATA,
  output logic [POST_AW+PRE_AW-1:0]  SYN_ADDR,
  input  logic [WEIGHT_WIDTH-1:0]    SYN_RDATA,
  output logic                       SYN_WE,
  output logic [WEIGHT_WIDTH-1:0]    SYN_WDATA,
  output logic                       UPD_EN,
  output logic                       UPD_IS_POS,
  output logic [POST_CNT_WIDTH-1:0]  UPD_POST_CNT,
  output logic [PRE_CNT_WIDTH-1:0]   UPD_PRE_CNT,
  output logic [WEIGHT_WIDTH-1:0]    UPD_WSYN_CURR,
  input  logic [WEIGHT_WIDTH-1:0]    UPD_WSYN_NEW
);

  seq_state_e                state_q, state_d;
  logic                      pol_q, pol_d;
  logic [POST_CNT_WIDTH-1:0] post_cnt_q, post_cnt_d;
  logic [WEIGHT_WIDTH-1:0]   wnew_q, wnew_d;
  logic [PRE_CNT_WIDTH-1:0]  pre_hold_q, pre_hold_d;
  logic [WEIGHT_WIDTH-1:0]   wcur_hold_q, wcur_hold_d;

  logic               idx_clr, idx_adv;
  logic [PRE_AW-1:0]  pre_idx;
  logic [POST_AW-1:0] post_idx;
  logic               pre_last, post_last;
  seq_state_e         after_syn;

  ffstdp_idx_counter #(
    .N_PRE   (N_PRE),
    .N_POST  (N_POST),
    .PRE_AW  (PRE_AW),
    .POST_AW (POST_AW)
  ) u_idx (
    .clk       (CLK),
    .rst       (RST),
    .clr       (idx_clr),
    .adv       (idx_adv),
    .pre_idx   (pre_idx),
    .post_idx  (post_idx),
    .pre_last  (pre_last),
    .post_last (post_last)
  );

  // Addresses follow the indices directly, so they stay put through SYN_UPD and SYN_WR.
  assign POST_CNT_ADDR = post_idx;
  assign PRE_CNT_ADDR  = pre_idx;
  assign SYN_ADDR      = {post_idx, pre_idx};

  assign BUSY      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign DONE      = (state_q == S_FIN);
  assign SYN_WE    = (state_q == S_SYN_WR);
  assign SYN_WDATA = wnew_q;
  assign UPD_EN    = (state_q == S_SYN_UPD);

  // Update-stage operands pass through live while enabled and hold their last value otherwise.
  assign UPD_IS_POS    = pol_q;
  assign UPD_POST_CNT  = post_cnt_q;
  assign UPD_PRE_CNT   = UPD_EN ? PRE_CNT_RDATA : pre_hold_q;
  assign UPD_WSYN_CURR = UPD_EN ? SYN_RDATA : wcur_hold_q;

  assign after_syn = !pre_last ? S_SYN_RD : (!post_last ? S_POST_RD : S_FIN);

  always_comb begin
    state_d     = state_q;
    pol_d       = pol_q;
    post_cnt_d  = post_cnt_q;
    wnew_d      = wnew_q;
    pre_hold_d  = pre_hold_q;
    wcur_hold_d = wcur_hold_q;
    idx_clr     = 1'b0;
    idx_adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          pol_d   = IS_POS_IN;
          idx_clr = 1'b1;
          state_d = S_POST_RD;
        end
      end
      S_POST_RD:  state_d = S_POST_LAT;
      S_POST_LAT: begin
        post_cnt_d = POST_CNT_RDATA;
        state_d    = S_SYN_RD;
      end
      S_SYN_RD:   state_d = S_SYN_UPD;
      S_SYN_UPD: begin
        wnew_d      = UPD_WSYN_NEW;
        pre_hold_d  = PRE_CNT_RDATA;
        wcur_hold_d = SYN_RDATA;
`ifdef FFSTDP_SKIP_ZERO_PRE_EN
        if (PRE_CNT_RDATA == '0) begin
          idx_adv = 1'b1;
          state_d = after_syn;
        end else begin
          state_d = S_SYN_WR;
        end
`else
        state_d = S_SYN_WR;
`endif
      end
      S_SYN_WR: begin
        idx_adv = 1'b1;
        state_d = after_syn;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pol_q       <= 1'b0;
      post_cnt_q  <= '0;
      wnew_q      <= '0;
      pre_hold_q  <= '0;
      wcur_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      pol_q       <= pol_d;
      post_cnt_q  <= post_cnt_d;
      wnew_q      <= wnew_d;
      pre_hold_q  <= pre_hold_d;
      wcur_hold_q <= wcur_hold_d;
    end
  end

endmodule

// File: tb/tb_ffstdp_update_seq.sv
// Self-checking bench for ffstdp_update_seq with a small 2x4 synapse array and a reference sweep model.
module tb_ffstdp_update_seq;

  localparam int NPRE  = 4;
  localparam int NPOST = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       is_pos_in = 1'b0;
  logic       busy, done;
  logic [0:0] post_addr;
  logic [6:0] post_rdata;
  logic [1:0] pre_addr;
  logic [7:0] pre_rdata;
  logic [2:0] syn_addr;
  logic [7:0] syn_rdata;
  logic       syn_we;
  logic [7:0] syn_wdata;
  logic       upd_en, upd_is_pos;
  logic [6:0] upd_post_cnt;
  logic [7:0] upd_pre_cnt, upd_wcurr, upd_wnew;

  logic [6:0] post_mem [NPOST];
  logic [7:0] pre_mem  [NPRE];
  logic [7:0] syn_mem  [NPOST*NPRE];
  int         upd_mode = 0;
  logic       exp_pol = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ffstdp_update_seq #(
    .N_PRE(NPRE), .N_POST(NPOST), .PRE_CNT_WIDTH(8), .POST_CNT_WIDTH(7), .WEIGHT_WIDTH(8)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .IS_POS_IN(is_pos_in),
    .BUSY(busy), .DONE(done),
    .POST_CNT_ADDR(post_addr), .POST_CNT_RDATA(post_rdata),
    .PRE_CNT_ADDR(pre_addr), .PRE_CNT_RDATA(pre_rdata),
    .SYN_ADDR(syn_addr), .SYN_RDATA(syn_rdata),
    .SYN_WE(syn_we), .SYN_WDATA(syn_wdata),
    .UPD_EN(upd_en), .UPD_IS_POS(upd_is_pos),
    .UPD_POST_CNT(upd_post_cnt), .UPD_PRE_CNT(upd_pre_cnt),
    .UPD_WSYN_CURR(upd_wcurr), .UPD_WSYN_NEW(upd_wnew)
  );

  // Update-stage stand-in; the reference model calls the same rule with operands taken from memory.
  function automatic logic [7:0] upd_fn(input int mode, input logic pos, input logic [6:0] post,
                                        input logic [7:0] pre, input logic [7:0] curr);
    if (mode == 0) return curr + 8'd1;
    if (pos) return curr + {5'd0, pre[2:0]} + {7'd0, post[0]};
    return curr - {5'd0, post[2:0]};
  endfunction

  assign upd_wnew = upd_fn(upd_mode, upd_is_pos, upd_post_cnt, upd_pre_cnt, upd_wcurr);

  always @(posedge clk) begin
    post_rdata <= post_mem[post_addr];
    pre_rdata  <= pre_mem[pre_addr];
    syn_rdata  <= syn_mem[syn_addr];
  end

  int          cyc = 0;
  int          busy_cnt = 0, done_cnt = 0, upd_cnt = 0, upd_bad = 0;
  int          last_busy_cyc = 0, last_done_cyc = 0;
  logic [10:0] wr_q [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (busy) begin
      busy_cnt      <= busy_cnt + 1;
      last_busy_cyc <= cyc;
    end
    if (done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (syn_we) wr_q.push_back({syn_addr, syn_wdata});
    if (upd_en) begin
      upd_cnt <= upd_cnt + 1;
      if (upd_is_pos !== exp_pol || upd_post_cnt !== post_mem[syn_addr[2]] ||
          upd_pre_cnt !== pre_mem[syn_addr[1:0]] || upd_wcurr !== syn_mem[syn_addr])
        upd_bad <= upd_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_mems();
    foreach (post_mem[i]) post_mem[i] = 7'($urandom_range(0, 127));
    foreach (pre_mem[i])  pre_mem[i]  = 8'($urandom_range(0, 255));
    foreach (syn_mem[i])  syn_mem[i]  = 8'($urandom_range(0, 255));
  endtask

  task automatic run_sweep(input string name, input logic pol, input bit poke);
    logic [10:0] exp_q [$];
    int exp_busy, b_busy, b_done, b_upd, b_bad, b_wr, t;
    exp_busy = 0;
    for (int po = 0; po < NPOST; po++) begin
      exp_busy += 2;
      for (int pr = 0; pr < NPRE; pr++) begin
        bit skip;
        skip = 1'b0;
`ifdef FFSTDP_SKIP_ZERO_PRE_EN
        skip = (pre_mem[pr] == 8'd0);
`endif
        exp_busy += skip ? 2 : 3;
        if (!skip)
          exp_q.push_back({3'(po * NPRE + pr),
                           upd_fn(upd_mode, pol, post_mem[po], pre_mem[pr], syn_mem[po * NPRE + pr])});
      end
    end
    b_busy = busy_cnt; b_done = done_cnt; b_upd = upd_cnt; b_bad = upd_bad; b_wr = wr_q.size();
    exp_pol = pol;
    @(posedge clk); #1;
    start = 1'b1; is_pos_in = pol;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (5) @(posedge clk);
      #1 start = 1'b1; is_pos_in = ~pol;
      @(posedge clk); #1;
      start = 1'b0; is_pos_in = pol;
    end
    t = 0;
    while (done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    @(negedge clk); @(negedge clk);
    chk({name, "_busy_len"}, 32'(busy_cnt - b_busy), 32'(exp_busy));
    chk({name, "_done_cnt"}, 32'(done_cnt - b_done), 32'd1);
    chk({name, "_done_after_busy"}, 32'(last_done_cyc), 32'(last_busy_cyc + 1));
    chk({name, "_upd_cnt"}, 32'(upd_cnt - b_upd), 32'(NPOST * NPRE));
    chk({name, "_upd_operands_bad"}, 32'(upd_bad - b_bad), 32'd0);
    chk({name, "_wr_cnt"}, 32'(wr_q.size() - b_wr), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (b_wr + i < wr_q.size()) ? wr_q[b_wr + i] : 11'h7ff;
      chk($sformatf("%s_wr%0d", name, i), 32'(got), 32'(exp_q[i]));
      $display("%s write %0d addr=%0d wdata=%0d expected_addr=%0d expected_wdata=%0d",
               name, i, got[10:8], got[7:0], exp_q[i][10:8], exp_q[i][7:0]);
    end
  endtask

  initial begin
    int we_seen, t, b_wr, b_done;
    randomize_mems();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_syn_we", 32'(syn_we), 32'd0);
    chk("rst_upd_en", 32'(upd_en), 32'd0);
    chk("rst_syn_addr", 32'(syn_addr), 32'd0);
    chk("rst_syn_wdata", 32'(syn_wdata), 32'd0);
    chk("rst_upd_is_pos", 32'(upd_is_pos), 32'd0);

    // Positive sweep, all weights 5, update adds 1, with a stray START mid-sweep.
    upd_mode = 0;
    foreach (syn_mem[i]) syn_mem[i] = 8'd5;
    run_sweep("pos_inc", 1'b1, 1'b1);
    chk("pos_inc_first_wdata", 32'(wr_q[0][7:0]), 32'd6);

    // Negative-polarity sweep with random contents.
    upd_mode = 1;
    randomize_mems();
    run_sweep("neg_rand", 1'b0, 1'b0);

    // Pre counts with zeros, exercising the optional skip path when built with it.
    randomize_mems();
    pre_mem[0] = 8'd0; pre_mem[1] = 8'd3; pre_mem[2] = 8'd0; pre_mem[3] = 8'd1;
    run_sweep("zero_pre", 1'b1, 1'b0);

    // Reset on the third write of a sweep aborts it.
    randomize_mems();
    @(posedge clk); #1 start = 1'b1; is_pos_in = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    we_seen = 0; t = 0;
    while (we_seen < 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (syn_we) we_seen++;
    end
    chk("abort_third_write_seen", 32'(we_seen), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_syn_we", 32'(syn_we), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    b_wr = wr_q.size(); b_done = done_cnt;
    repeat (40) @(negedge clk);
    chk("abort_no_more_writes", 32'(wr_q.size() - b_wr), 32'd0);
    chk("abort_no_done", 32'(done_cnt - b_done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    $display("abort sweep: writes_before_reset=%0d", we_seen);

    // Clean sweep after abort, random polarity.
    randomize_mems();
    run_sweep("recover", 1'($urandom_range(0, 1)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
